// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled with `define IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // True when a program of n words fits a memory of 2**addr_w words.
  function automatic logic count_fits(input logic [15:0] n, input int unsigned addr_w);
    return 32'(n) <= (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
// master: the loader (accepts bytes, drives memory writes); slave: the environment.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler. Lanes 0..2 are held in a register;
// the top lane comes straight from the incoming byte so the completed word
// is available on the same cycle as the final byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte_data,
  output logic            o_word_valid,
  output logic [XLEN-1:0] o_word
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  logic [LANE_W-1:0] r_lane;
  logic [XLEN-9:0]   r_lanes;

  // Advance the lane index and capture the byte into its lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane  <= '0;
      r_lanes <= '0;
    end else if (i_byte_valid) begin
      r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
      for (int k = 0; k < WORD_BYTES - 1; k++) begin
        if (r_lane == LANE_W'(k)) begin
          r_lanes[8*k +: 8] <= i_byte_data;
        end
      end
    end
  end

  assign o_word_valid = i_byte_valid && (r_lane == LAST_LANE);
  assign o_word       = {i_byte_data, r_lanes};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a counted byte frame, writes words to
// consecutive addresses from 0, and holds the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            r_state;
  state_t            w_state_d;
  logic [15:0]       r_count;
  logic [15:0]       r_word_idx;
  logic              r_byte_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_core_reset;
  logic              r_done;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_xfer;
  logic              w_asm_valid;
  logic              w_word_valid;
  logic [XLEN-1:0]   w_word;
  logic [15:0]       w_count_full;
  logic              w_last_word;

  assign w_xfer       = bus.byte_valid && r_byte_ready;
  assign w_asm_valid  = w_xfer && (r_state == S_DATA);
  assign w_count_full = {bus.byte_data, r_count[7:0]};
  assign w_last_word  = (r_word_idx == r_count - 16'd1);

  imem_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_byte_valid (w_asm_valid),
    .i_byte_data  (bus.byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Next-state decode; state only moves on an accepted byte.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_CNT_LO: if (w_xfer) w_state_d = S_CNT_HI;
      S_CNT_HI: begin
        if (w_xfer) begin
          if (w_count_full == 16'd0) begin
            w_state_d = S_END;
          end else if (!count_fits(w_count_full, ADDR_W)) begin
            w_state_d = S_ERR;
          end else begin
            w_state_d = S_DATA;
          end
        end
      end
      S_DATA: if (w_word_valid && w_last_word) w_state_d = S_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer) w_state_d = (bus.byte_data == r_csum) ? S_DONE : S_ERR;
      end
`else
      S_CSUM: w_state_d = S_ERR;
`endif
      S_DONE:  w_state_d = S_DONE;
      S_ERR:   w_state_d = S_ERR;
      default: w_state_d = S_ERR;
    endcase
  end

  // State register plus all registered outputs, counters and write bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_CNT_LO;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_byte_ready <= (w_state_d == S_CNT_LO) || (w_state_d == S_CNT_HI) ||
                      (w_state_d == S_DATA) || (w_state_d == S_CSUM);
      r_we         <= w_word_valid;
      r_done       <= (w_state_d == S_DONE);
      r_err        <= (w_state_d == S_ERR);
      // Lags S_DONE by one edge so the final write completes with the core held.
      r_core_reset <= (r_state != S_DONE);

      if (w_xfer && (r_state == S_CNT_LO)) r_count[7:0]  <= bus.byte_data;
      if (w_xfer && (r_state == S_CNT_HI)) r_count[15:8] <= bus.byte_data;

      if (w_word_valid) begin
        r_addr     <= r_word_idx[ADDR_W-1:0];
        r_wdata    <= w_word;
        r_word_idx <= r_word_idx + 16'd1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_xfer) r_csum <= r_csum ^ bus.byte_data;
`endif
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_reset     = r_core_reset;
  assign load_done      = r_done;
  assign load_error     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frame scenarios plus a
// hand-written mid-word reset sequence. Follows IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int unsigned ADDR_W   = 8;
  localparam int          WAIT_MAX = 50;
  localparam int          K_TWO    = 0;
  localparam int          K_ZERO   = 1;
  localparam int          K_OVER   = 2;
  localparam int          K_BADSUM = 3;

  typedef struct {
    string name;
    int    kind;
    int    gap_mode;
    logic  exp_ready;
    logic  exp_done;
    logic  exp_err;
    logic  exp_crst;
    int    exp_writes;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_reset;
  logic load_done;
  logic load_error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_done = 0;
  int t_rel = 0;
  logic prev_done = 1'b0;
  logic prev_crst = 1'b1;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  int                log_cyc[$];
  logic [7:0]        frm[$];
  vec_t              vecs[$];

  logic [7:0] two_addi [10] = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h30, 8'h00,
                                8'h93, 8'h82, 8'h42, 8'h00};
  logic [31:0] exp_words [2] = '{32'h0030_0293, 32'h0042_8293};
  int          exp_x5 [2]    = '{3, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor and done/release timestamps, sampled on the falling edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_done <= load_done;
    prev_crst <= core_reset;
    if (bus.imem_we === 1'b1) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_wdata);
      log_cyc.push_back(cyc);
      chk("core_reset_during_write", core_reset, 1);
    end
    if (load_done && !prev_done) t_done <= cyc;
    if (!core_reset && prev_crst) t_rel <= cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_error", load_error, 0);
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    reset = 1'b0;
  endtask

  // Entered and left on a falling edge; the byte transfers on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) begin
      checks++;
      failures++;
      $display("FAIL ready_wait byte=%0h waited=%0d cycles required<%0d", b, n, WAIT_MAX);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int gap_mode);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], (gap_mode != 0) ? (i % 4) : 0);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic build_frame(input int kind);
    frm.delete();
    case (kind)
      K_ZERO: begin
        frm.push_back(8'h00);
        frm.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frm.push_back(8'h00);
`endif
      end
      K_OVER: begin
        frm.push_back(8'h01);
        frm.push_back(8'h01);
      end
      default: begin
        for (int i = 0; i < 10; i++) frm.push_back(two_addi[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frm.push_back((kind == K_BADSUM) ? 8'hF1 : 8'hF0);
`endif
      end
    endcase
  endtask

  // Tiny ADDI-only core model run over the logged program.
  task automatic check_core(input string name);
    int x [32];
    for (int r = 0; r < 32; r++) x[r] = 0;
    for (int i = 0; i < log_data.size(); i++) begin
      logic [31:0] w;
      int imm;
      w   = log_data[i];
      imm = $signed(w[31:20]);
      if (w[6:0] == 7'h13 && w[14:12] == 3'd0 && w[11:7] != 5'd0) begin
        x[w[11:7]] = x[w[19:15]] + imm;
      end
      chk({name, "_core_x5"}, x[5], exp_x5[i]);
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    vecs.push_back('{"two_addi", K_TWO,  0, 1'b0, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{"two_gaps", K_TWO,  1, 1'b0, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{"zero_cnt", K_ZERO, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{"over_cnt", K_OVER, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0});
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back('{"bad_csum", K_BADSUM, 0, 1'b0, 1'b0, 1'b1, 1'b1, 2});
`endif

    for (int v = 0; v < vecs.size(); v++) begin
      vec_t t;
      t = vecs[v];
      do_reset();
      build_frame(t.kind);
      send_frame(t.gap_mode);
      repeat (6) @(negedge clk);

      chk({t.name, "_byte_ready"}, bus.byte_ready, t.exp_ready);
      chk({t.name, "_load_done"}, load_done, t.exp_done);
      chk({t.name, "_load_error"}, load_error, t.exp_err);
      chk({t.name, "_core_reset"}, core_reset, t.exp_crst);
      chk({t.name, "_writes"}, log_data.size(), t.exp_writes);

      if (t.exp_writes == 2 && log_data.size() == 2) begin
        for (int i = 0; i < 2; i++) begin
          chk({t.name, "_addr"}, log_addr[i], i);
          chk({t.name, "_wdata"}, log_data[i], exp_words[i]);
        end
        chk({t.name, "_hold_addr"}, bus.imem_addr, 1);
        chk({t.name, "_hold_wdata"}, bus.imem_wdata, exp_words[1]);
        check_core(t.name);
        if (t.gap_mode == 0) chk({t.name, "_word_spacing"}, log_cyc[1] - log_cyc[0], 4);
      end
      if (t.exp_done) chk({t.name, "_release_delay"}, t_rel - t_done, 1);
    end

    // Reset after two data bytes of word 0, then a fresh one-word frame.
    do_reset();
    frm.delete();
    frm.push_back(8'h02);
    frm.push_back(8'h00);
    frm.push_back(8'h93);
    frm.push_back(8'h02);
    send_frame(0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_write", log_data.size(), 0);
    chk("midrst_core_reset", core_reset, 1);
    reset = 1'b0;
    frm.delete();
    frm.push_back(8'h01);
    frm.push_back(8'h00);
    frm.push_back(8'h93);
    frm.push_back(8'h02);
    frm.push_back(8'h30);
    frm.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    frm.push_back(8'hA0);
`endif
    send_frame(0);
    repeat (6) @(negedge clk);
    chk("midrst_writes", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("midrst_addr", log_addr[0], 0);
      chk("midrst_wdata", log_data[0], 32'h0030_0293);
    end
    chk("midrst_load_done", load_done, 1);
    chk("midrst_load_error", load_error, 0);
    chk("midrst_core_reset_low", core_reset, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
